// File: rtl/rsa_operand_loader.sv
// rsa_operand_loader
// Buffers the three 1024-bit RSA operands (modulus n, ciphertext m, exponent e)
// arriving word by word from a host, then streams them to MonPro as one
// (n, m, e) word triple per clock with startInput held high for the whole burst.
module rsa_operand_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_sel,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  start_stream,
  output logic                  startInput,
  output logic [DATA_WIDTH-1:0] n_input,
  output logic [DATA_WIDTH-1:0] m_input,
  output logic [DATA_WIDTH-1:0] e_input,
  output logic [2:0]            loaded,
  output logic                  busy,
  output logic                  sel_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Count value meaning "bank holds all DEPTH words"; also the read index
  // value at which the burst has finished.
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [1:0] SEL_N   = 2'd0;
  localparam logic [1:0] SEL_M   = 2'd1;
  localparam logic [1:0] SEL_E   = 2'd2;
  localparam logic [1:0] SEL_RSV = 2'd3;

  typedef enum logic {
    LOAD,
    STREAM
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] bank_n [DEPTH];
  logic [DATA_WIDTH-1:0] bank_m [DEPTH];
  logic [DATA_WIDTH-1:0] bank_e [DEPTH];

  // Write counts run 0..DEPTH, so they are one bit wider than a word index.
  logic [ADDR_WIDTH:0] wcnt_n, wcnt_m, wcnt_e;
  logic [ADDR_WIDTH:0] rd_idx;

  logic sel_free;
  logic accept;
  logic start_ok;
  logic stream_done;

  assign loaded = {(wcnt_e == FULL), (wcnt_m == FULL), (wcnt_n == FULL)};

  // Per-select space check; the reserved select always accepts so the word
  // can be consumed and flagged rather than stalling the host.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which is what would otherwise infer a latch.
    sel_free = 1'b0;
    unique case (in_sel)
      SEL_N:   sel_free = !loaded[0];
      SEL_M:   sel_free = !loaded[1];
      SEL_E:   sel_free = !loaded[2];
      SEL_RSV: sel_free = 1'b1;
      default: sel_free = 1'b0;
    endcase
  end

  assign in_ready    = (state == LOAD) && sel_free;
  assign accept      = in_valid && in_ready;
  assign start_ok    = (state == LOAD) && start_stream && (loaded == 3'b111);
  assign stream_done = (state == STREAM) && (rd_idx == FULL);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset) state <= LOAD;
    else        state <= state_next;
  end

  // Next-state logic: leave LOAD on an accepted start, return after the burst.
  always_comb begin
    state_next = state;
    unique case (state)
      LOAD:    if (start_ok)    state_next = STREAM;
      STREAM:  if (stream_done) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Per-bank write counters; all cleared once a burst has been delivered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt_n <= '0;
      wcnt_m <= '0;
      wcnt_e <= '0;
    end else if (stream_done) begin
      wcnt_n <= '0;
      wcnt_m <= '0;
      wcnt_e <= '0;
    end else if (accept) begin
      unique case (in_sel)
        SEL_N:   wcnt_n <= wcnt_n + 1'b1;
        SEL_M:   wcnt_m <= wcnt_m + 1'b1;
        SEL_E:   wcnt_e <= wcnt_e + 1'b1;
        default: ;
      endcase
    end
  end

  // Operand storage writes at the bank's current fill position.
  always_ff @(posedge clk) begin
    // NOTE: the banks have no reset; their contents are meaningless until the
    // write counters say otherwise, and leaving them unreset lets them map to RAM.
    if (accept) begin
      unique case (in_sel)
        SEL_N:   bank_n[wcnt_n[ADDR_WIDTH-1:0]] <= in_data;
        SEL_M:   bank_m[wcnt_m[ADDR_WIDTH-1:0]] <= in_data;
        SEL_E:   bank_e[wcnt_e[ADDR_WIDTH-1:0]] <= in_data;
        default: ;
      endcase
    end
  end

  // Registered stream outputs, read index and the reserved-select error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      startInput <= 1'b0;
      busy       <= 1'b0;
      n_input    <= '0;
      m_input    <= '0;
      e_input    <= '0;
      rd_idx     <= '0;
      sel_err    <= 1'b0;
    end else begin
      sel_err <= accept && (in_sel == SEL_RSV);
      if (start_ok) begin
        n_input    <= bank_n[0];
        m_input    <= bank_m[0];
        e_input    <= bank_e[0];
        startInput <= 1'b1;
        busy       <= 1'b1;
        rd_idx     <= (ADDR_WIDTH + 1)'(1);
      end else if (stream_done) begin
        n_input    <= '0;
        m_input    <= '0;
        e_input    <= '0;
        startInput <= 1'b0;
        busy       <= 1'b0;
        rd_idx     <= '0;
      end else if (state == STREAM) begin
        n_input <= bank_n[rd_idx[ADDR_WIDTH-1:0]];
        m_input <= bank_m[rd_idx[ADDR_WIDTH-1:0]];
        e_input <= bank_e[rd_idx[ADDR_WIDTH-1:0]];
        rd_idx  <= rd_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Testbench for rsa_operand_loader: random operand loads checked against a
// queue-based model of the three operand buffers and the stream they produce.
module tb_rsa_operand_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_data;
  logic        start_stream;
  logic        startInput;
  logic [31:0] n_input, m_input, e_input;
  logic [2:0]  loaded;
  logic        busy;
  logic        sel_err;

  int checks = 0;
  int errors = 0;

  // Model: each operand is simply the ordered list of words the host got in.
  logic [31:0] q_n[$];
  logic [31:0] q_m[$];
  logic [31:0] q_e[$];

  rsa_operand_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .start_stream(start_stream),
    .startInput(startInput), .n_input(n_input), .m_input(m_input),
    .e_input(e_input), .loaded(loaded), .busy(busy), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  function automatic int model_len(input logic [1:0] sel);
    case (sel)
      2'd0:    return q_n.size();
      2'd1:    return q_m.size();
      2'd2:    return q_e.size();
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] model_loaded();
    return {q_e.size() == 32, q_m.size() == 32, q_n.size() == 32};
  endfunction

  function automatic void model_clear();
    q_n.delete();
    q_m.delete();
    q_e.delete();
  endfunction

  // All tasks start and end one time unit after a rising edge.
  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One host word; checks in_ready before the edge and sel_err after it.
  task automatic write_word(input logic [1:0] sel, input logic [31:0] d);
    logic exp_rdy;
    exp_rdy  = (sel == 2'd3) || (model_len(sel) < 32);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    @(negedge clk);
    checks++;
    if (in_ready !== exp_rdy)
      $display("FAIL in_ready sel=%0d: got %b expected %b", sel, in_ready, exp_rdy);
    if (in_ready !== exp_rdy) errors++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (exp_rdy) begin
      case (sel)
        2'd0: q_n.push_back(d);
        2'd1: q_m.push_back(d);
        2'd2: q_e.push_back(d);
        default: ;
      endcase
    end
    checks++;
    if (sel_err !== (sel == 2'd3)) begin
      errors++;
      $display("FAIL sel_err after sel=%0d: got %b expected %b", sel, sel_err, sel == 2'd3);
    end
  endtask

  // Fill the masked banks with random words, interleaved n/m/e, random gaps.
  task automatic load_random(input logic [2:0] mask);
    for (int i = 0; i < 32; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (mask[b]) write_word(2'(b), $urandom);
        if ($urandom_range(0, 5) == 0) idle(1);
      end
    end
  endtask

  task automatic check_loaded(input string tag);
    checks++;
    if (loaded !== model_loaded()) begin
      errors++;
      $display("FAIL loaded %s: got %b expected %b", tag, loaded, model_loaded());
    end
  endtask

  // Pulse start and verify the whole 32-word burst plus the return to idle.
  // With rsv_word set, a reserved-select word is offered on the start edge.
  task automatic stream_and_check(input string tag, input logic rsv_word);
    start_stream = 1'b1;
    if (rsv_word) begin
      in_valid = 1'b1;
      in_sel   = 2'd3;
      in_data  = 32'hDEADBEEF;
    end
    @(posedge clk);
    #1;
    start_stream = 1'b0;
    in_valid     = 1'b0;
    in_sel       = 2'd0;
    if (rsv_word) begin
      checks++;
      if (sel_err !== 1'b1) begin
        errors++;
        $display("FAIL %s sel_err on start: got %b expected 1", tag, sel_err);
      end
    end
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (startInput !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 ||
          n_input !== q_n[k] || m_input !== q_m[k] || e_input !== q_e[k]) begin
        errors++;
        $display("FAIL %s word %0d: got si=%b busy=%b rdy=%b n=%h m=%h e=%h expected si=1 busy=1 rdy=0 n=%h m=%h e=%h",
                 tag, k, startInput, busy, in_ready, n_input, m_input, e_input, q_n[k], q_m[k], q_e[k]);
      end
      idle(1);
    end
    model_clear();
    checks++;
    if (startInput !== 1'b0 || busy !== 1'b0 || loaded !== 3'b000 ||
        n_input !== 32'h0 || m_input !== 32'h0 || e_input !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s end of stream: got si=%b busy=%b loaded=%b n=%h m=%h e=%h rdy=%b expected all 0, rdy=1",
               tag, startInput, busy, loaded, n_input, m_input, e_input, in_ready);
    end
  endtask

  task automatic test_reset;
    write_word(2'd0, $urandom);
    write_word(2'd1, $urandom);
    reset = 1'b0;
    #1;
    model_clear();
    checks++;
    if (startInput !== 1'b0 || busy !== 1'b0 || sel_err !== 1'b0 || loaded !== 3'b000 ||
        n_input !== 32'h0 || m_input !== 32'h0 || e_input !== 32'h0) begin
      errors++;
      $display("FAIL reset values: got si=%b busy=%b sel_err=%b loaded=%b n=%h m=%h e=%h expected all 0",
               startInput, busy, sel_err, loaded, n_input, m_input, e_input);
    end
    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin
      in_sel = 2'(s);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_ready after reset sel=%0d: got %b expected 1", s, in_ready);
      end
    end
    in_sel = 2'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_stream;
    write_word(2'd0, 32'h8B9496E5);
    write_word(2'd1, 32'h40C517E0);
    write_word(2'd2, 32'h70A34C81);
    write_word(2'd0, 32'h5F06287C);
    for (int i = 1; i < 32; i++) begin
      if (i > 1) write_word(2'd0, $urandom);
      write_word(2'd1, $urandom);
      write_word(2'd2, $urandom);
    end
    check_loaded("full");
    stream_and_check("load_stream", 1'b0);
  endtask

  task automatic test_premature_overflow;
    logic [31:0] junk;
    load_random(3'b011);
    check_loaded("n,m only");
    start_stream = 1'b1;
    idle(1);
    start_stream = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy !== 1'b0 || startInput !== 1'b0) begin
        errors++;
        $display("FAIL premature start cycle %0d: got busy=%b si=%b expected 0", c, busy, startInput);
      end
      idle(1);
    end
    junk = $urandom;
    write_word(2'd0, junk);
    check_loaded("after overflow");
    load_random(3'b100);
    stream_and_check("overflow", 1'b0);
  endtask

  task automatic test_reserved_sel;
    load_random(3'b001);
    write_word(2'd3, 32'hDEADBEEF);
    check_loaded("after reserved");
    idle(1);
    checks++;
    if (sel_err !== 1'b0) begin
      errors++;
      $display("FAIL sel_err width: got %b expected 0", sel_err);
    end
    load_random(3'b110);
    stream_and_check("reserved", 1'b1);
  endtask

  task automatic test_reset_mid_stream;
    load_random(3'b111);
    start_stream = 1'b1;
    idle(1);
    start_stream = 1'b0;
    idle(10);
    checks++;
    if (n_input !== q_n[10] || startInput !== 1'b1) begin
      errors++;
      $display("FAIL word 10 before reset: got n=%h si=%b expected n=%h si=1", n_input, startInput, q_n[10]);
    end
    reset = 1'b0;
    #1;
    model_clear();
    checks++;
    if (startInput !== 1'b0 || busy !== 1'b0 || n_input !== 32'h0) begin
      errors++;
      $display("FAIL reset mid-stream: got si=%b busy=%b n=%h expected 0", startInput, busy, n_input);
    end
    reset = 1'b1;
    #1;
    check_loaded("after mid-stream reset");
    @(posedge clk);
    #1;
    load_random(3'b111);
    stream_and_check("after reset", 1'b0);
  endtask

  task automatic test_back_to_back;
    load_random(3'b111);
    stream_and_check("b2b first", 1'b0);
    load_random(3'b111);
    check_loaded("b2b second");
    stream_and_check("b2b second", 1'b0);
  endtask

  initial begin
    reset        = 1'b0;
    in_valid     = 1'b0;
    in_sel       = 2'd0;
    in_data      = 32'h0;
    start_stream = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    test_reset();
    test_load_stream();
    test_premature_overflow();
    test_reserved_sel();
    test_reset_mid_stream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rsa_operand_loader.md
# rsa_operand_loader

Upstream stage of the MonPro Montgomery exponentiation core. It accepts the three 1024-bit operands from a host word by word: modulus n, ciphertext m and private exponent e. Each operand arrives as 32 × 32-bit words, least-significant word first. Once all three are buffered, the block streams them to MonPro in lock-step: one (n, m, e) word triple per clock, with `startInput` held high for exactly 32 cycles.

## Interface
- `DATA_WIDTH`, default 32: word width.
- `ADDR_WIDTH`, default 5: word-index width; an operand is `2**ADDR_WIDTH` = 32 words.
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  block can accept a word for the bank selected by `in_sel`.
- `in_sel`  in  2  target bank: 0 = n, 1 = m, 2 = e, 3 = reserved.
- `in_data`  in  DATA_WIDTH  host word.
- `start_stream`  in  1  request to stream buffered operands to MonPro.
- `startInput`  out  1  to MonPro; high while word triples are valid.
- `n_input`, `m_input`, `e_input`  out  DATA_WIDTH each  to MonPro; current word triple.
- `loaded`  out  3  per-bank full flags; bit0 = n, bit1 = m, bit2 = e.
- `busy`  out  1  streaming in progress.
- `sel_err`  out  1  one-cycle pulse when a word with `in_sel`=3 is accepted and dropped.

## Operation
- Storage: three 32×32 banks. Each bank has a 6-bit write count, `wcnt`, in the range 0..32.
- States: LOAD (reset state) and STREAM.
- LOAD, host writes:
  - `in_ready` = (`in_sel`==3) OR (`wcnt[in_sel]` < 32). This is combinational on `in_sel`.
  - A transfer happens on `in_valid && in_ready`.
  - For `in_sel` 0..2, `in_data` is written to `bank[in_sel][wcnt]` and that `wcnt` increments.
  - For `in_sel`=3, the word is discarded and `sel_err` pulses high for the next cycle.
- `loaded[i]` = (`wcnt[i]`==32). A bank that is full holds `in_ready` low for its select and is never overwritten.
- LOAD, `start_stream`:
  - Sampled only when `loaded`==3'b111; otherwise it is ignored, with no latching and no error.
  - When accepted at edge t0: the outputs load word 0 of each bank, `startInput` and `busy` go to 1, the read index k becomes 1, and the state moves to STREAM.
- STREAM:
  - `in_ready`=0 and host input is ignored.
  - Each edge while k<32: the outputs load `bank[*][k]` and k increments.
  - On the edge after word 31 has been presented: `startInput`, `busy` and the data outputs go to 0; all `wcnt` and `loaded` clear; the state returns to LOAD.
- Simultaneous `in_valid` with `sel`=3 and accepted `start_stream` at t0: the word is dropped, `sel_err` pulses, and the stream proceeds.
- Banks 0..2 are all full whenever `start_stream` can be accepted, so no write to them can coincide with the stream start.
- Arithmetic: `wcnt` saturates at 32 by construction because of `in_ready`. k is 6 bits and never wraps.

## Timing
- Reset (asynchronous, `reset`=0):
  - `startInput`=0, `n_input`/`m_input`/`e_input`=0, `busy`=0, `sel_err`=0, `loaded`=000.
  - All `wcnt`=0, k=0, state LOAD. Bank contents are don't-care.
  - This applies mid-load or mid-stream; an aborted stream is not resumed.
- `in_ready` after reset release: high combinationally in the first cycle after `reset` deasserts.
- Stream start:
  - Latency from the accepting edge t0 to word 0 on the outputs is 1 edge; the outputs are registered.
  - Word k is valid in the cycle between edges t0+k and t0+k+1, for k = 0..31.
- `startInput` is high for exactly 32 consecutive cycles, with no gaps.
- The first new host word can be accepted at edge t0+33.
- Minimum full cycle: 96 load cycles + 1 start cycle + 32 stream cycles.

## Test plan
- Reset values: assert `reset`=0 mid-simulation → all outputs are 0, `loaded`=000, and `in_ready`=1 for `sel` 0..2 once `reset` is released.
- Full load and stream:
  - Stimulus: write n words 32'h8B9496E5, 32'h5F06287C, …; m words 32'h40C517E0, …; e words 32'h70A34C81, …; 32 each, in interleaved order. Then pulse `start_stream`.
  - Required response: `loaded`=111; `startInput` high 32 cycles; cycle 0 shows n=8B9496E5, m=40C517E0, e=70A34C81; cycle 1 shows n=5F06287C; word order matches write order; everything returns to 0 afterwards.
- Premature start and overflow:
  - `start_stream` with only n and m full → ignored: `busy` stays 0.
  - A 33rd write to bank n → `in_ready`=0 and `bank[0]` is unchanged.
- Reserved select:
  - `in_sel`=3, `in_data`=32'hDEADBEEF → accepted, `sel_err` pulses one cycle, no `wcnt` changes.
- Reset mid-stream:
  - Drop `reset` at stream word 10 → `startInput` goes to 0 immediately; after release, `loaded`=000.
  - A fresh load and stream then presents the new word 0 correctly.
- Back-to-back:
  - Second load starts at edge t0+33 → accepted.
  - Second stream's data is entirely the new values, with no stale words.
